iomem_wb_bridge: RTL and testbench
==================================

# iomem_wb_bridge

Parametrised bridge from the picosoc `iomem` bus to a multi-slave Wishbone bus. It replaces the single-slave inline bridge FSM in the SoC top level. It adds:
- address decode with per-slave strobes;
- a bus-error response for unmapped addresses;
- a watchdog timeout for slaves that never acknowledge.

It sits between `picosoc` and the Wishbone peripherals, such as `wb_buttons_leds`.

## Interface
- `NUM_SLAVES`, 4: number of Wishbone slaves, 1..8.
- `SLAVE_BASE`, {0x0600_0000, 0x0500_0000, 0x0400_0000, 0x0300_0000}: packed 32×NUM_SLAVES base addresses; slave 0 occupies the LSBs.
- `SLAVE_MASK`, all 0xFF00_0000: packed 32×NUM_SLAVES match masks.
- `TIMEOUT_CYCLES`, 255: maximum wait for an ack, 1..65535.
- `ERR_DATA`, 0xDEAD_BEEF: read data returned on an error.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `iomem_valid` in 1: request from picosoc.
- `iomem_ready` out 1: one-cycle completion pulse.
- `iomem_wstrb` in 4: byte write strobes; 0 means a read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data; valid while `iomem_ready`=1.
- `wbm_adr_o` out 32, `wbm_dat_o` out 32, `wbm_we_o` out 1, `wbm_sel_o` out 4: shared Wishbone master signals.
- `wbm_cyc_o` out 1: shared cycle signal.
- `wbm_stb_o` out NUM_SLAVES: one-hot per-slave strobe.
- `wbm_ack_i` in NUM_SLAVES: per-slave ack.
- `wbm_dat_i` in 32×NUM_SLAVES: packed per-slave read data.
- `err_count` out 8: saturating count of bus errors (unmapped accesses plus timeouts).

## Operation
- Reset values: all outputs 0; FSM in IDLE.
- Address decode: slave i hits when `(iomem_addr & MASK[i]) == BASE[i]`. On multiple hits, the lowest index wins.

FSM states and transitions:
- **IDLE**
  - `iomem_valid`=1 and a slave hits: latch `adr`, `dat`, `we = |wstrb`, and `sel = wstrb`, or 4'hF on reads. Assert `cyc` and `stb[hit]`. Go to WAIT.
  - `iomem_valid`=1 and no slave hits: `iomem_rdata`=ERR_DATA, `iomem_ready`=1, increment `err_count`. Go to DONE. No Wishbone cycle is issued.
- **WAIT**
  - On `wbm_ack_i[sel]`: capture `wbm_dat_i[sel]` into `iomem_rdata`, pulse `iomem_ready`, deassert `cyc`, `stb` and `we`. Go to DONE.
  - Acks from non-selected slaves are ignored.
- **DONE**
  - `iomem_ready`=0. Go to IDLE. This gives picosoc one cycle to drop `valid`.

Other rules:
- Write completions return `iomem_rdata`=captured `wbm_dat_i` (don't-care for the CPU).
- `err_count` saturates at 255 and never wraps.
- Reset mid-transaction aborts the Wishbone cycle immediately: `cyc`/`stb` low on the next edge, and no `iomem_ready` pulse.

## Timing
- Request sampled at edge N: `cyc`/`stb` high from edge N+1.
- Slave ack during the cycle after edge N+k (k≥1): `iomem_ready` high for exactly one cycle after edge N+k+1.
- Fastest transaction, with a combinational ack in the first strobe cycle: ready 2 cycles after the request.
- Unmapped access: ready 1 cycle after the request.
- Back-to-back throughput: 1 transaction per (ack latency + 3) cycles.
- `wbm_adr_o`, `wbm_dat_o`, `wbm_we_o` and `wbm_sel_o` are stable for the whole cycle.

## Configuration
- `IOMEM_WB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no ack: deassert `cyc`/`stb`, `iomem_rdata`=ERR_DATA, pulse `iomem_ready`, increment `err_count`, go to DONE.
  - An ack in the same cycle as expiry takes priority: normal completion.
- Not defined: no counter; WAIT holds indefinitely; `err_count` counts unmapped accesses only.

## Structure
- Package `iomem_wb_pkg`:
  - FSM state enum (IDLE, WAIT, DONE);
  - default ERR_DATA;
  - the width constant for `err_count`.
- Sub-module `iomem_wb_decode`: combinational priority decoder. Takes the address and parameters; outputs `hit` (1 bit) and `sel_idx` ($clog2(NUM_SLAVES) bits).

## Test plan
Test setup: defaults, `IOMEM_WB_TIMEOUT_EN` defined, TIMEOUT_CYCLES=16. `wb_buttons_leds` is on slave 0; stub slaves on 1–3.
1. Write 0x0000_00A5, wstrb=4'hF to 0x0300_0000 -> `stb[0]` only, `we`=1, `sel`=4'hF; LEDs read back 0xA5; ready pulse exactly 1 cycle.
2. Read 0x0400_0004, slave 1 acks after 3 cycles with 0x1234_5678 -> `sel`=4'hF, `we`=0; `iomem_rdata`=0x1234_5678 at ready; `stb[0,2,3]` never high.
3. Read 0x0700_0000 (unmapped) -> no `cyc`; ready next cycle with 0xDEAD_BEEF; `err_count`=1.
4. Slave 2 never acks -> `cyc` drops after 16 WAIT cycles; ready with 0xDEAD_BEEF; `err_count` increments. Then 300 further timeouts -> `err_count`=255.
5. Spurious `ack[3]` while waiting on slave 1 -> ignored; completion only on `ack[1]`.
6. Assert `resetn`=0 mid-WAIT -> `cyc`/`stb`/`iomem_ready` all 0 next edge; a subsequent read completes normally.

Source files
------------

// File: rtl/iomem_wb_pkg.sv
// Shared types and constants for the iomem-to-Wishbone bridge.
package iomem_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          ERR_CNT_W        = 8;

  // Slave index width; a one-slave bus still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iomem_wb_decode.sv
// Combinational priority address decoder: slave i hits when
// (addr & MASK[i]) == BASE[i]; the lowest matching index wins.
module iomem_wb_decode
  import iomem_wb_pkg::*;
#(
  parameter int                       NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = '0,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = '0,
  parameter int                       IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] sel_idx
);

  // Walk from the highest index down so the lowest match is written last.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit     = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/iomem_wb_bridge.sv
// picosoc iomem to multi-slave Wishbone bridge with address decode and bus-error
// responses. Define IOMEM_WB_TIMEOUT_EN to add the per-access ack watchdog.
module iomem_wb_bridge
  import iomem_wb_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {32'h0600_0000, 32'h0500_0000,
                                                        32'h0400_0000, 32'h0300_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {NUM_SLAVES{32'hFF00_0000}},
  parameter int                       TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       iomem_valid,
  output logic                       iomem_ready,
  input  logic [3:0]                 iomem_wstrb,
  input  logic [31:0]                iomem_addr,
  input  logic [31:0]                iomem_wdata,
  output logic [31:0]                iomem_rdata,
  output logic [31:0]                wbm_adr_o,
  output logic [31:0]                wbm_dat_o,
  output logic                       wbm_we_o,
  output logic [3:0]                 wbm_sel_o,
  output logic                       wbm_cyc_o,
  output logic [NUM_SLAVES-1:0]      wbm_stb_o,
  input  logic [NUM_SLAVES-1:0]      wbm_ack_i,
  input  logic [32*NUM_SLAVES-1:0]   wbm_dat_i,
  output logic [ERR_CNT_W-1:0]       err_count
);

  localparam int IDX_W = idx_width(NUM_SLAVES);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_num_slaves
    $error("iomem_wb_bridge: NUM_SLAVES must be 1..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("iomem_wb_bridge: TIMEOUT_CYCLES must be 1..65535");
  end

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    cyc_d, we_d, ready_d, err_inc;
  logic [NUM_SLAVES-1:0]   stb_d;
  logic [31:0]             adr_d, dat_d, rdata_d;
  logic [3:0]              sel_d;
  logic [ERR_CNT_W-1:0]    err_d;
  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic                    ack_sel;
  logic [31:0]             dat_sel;

  iomem_wb_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr    (iomem_addr),
    .hit     (dec_hit),
    .sel_idx (dec_idx)
  );

  // Only the slave latched at request time may complete the access.
  assign ack_sel = wbm_ack_i[idx_q];
  assign dat_sel = wbm_dat_i[idx_q*32 +: 32];

`ifdef IOMEM_WB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    // NOTE: every next-state value gets a default first so this block never infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = wbm_cyc_o;
    stb_d   = wbm_stb_o;
    we_d    = wbm_we_o;
    adr_d   = wbm_adr_o;
    dat_d   = wbm_dat_o;
    sel_d   = wbm_sel_o;
    rdata_d = iomem_rdata;
    ready_d = 1'b0;
    err_inc = 1'b0;
`ifdef IOMEM_WB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (iomem_valid) begin
          if (dec_hit) begin
            state_d = WAIT;
            idx_d   = dec_idx;
            cyc_d   = 1'b1;
            stb_d   = NUM_SLAVES'(1) << dec_idx;
            we_d    = |iomem_wstrb;
            adr_d   = iomem_addr;
            dat_d   = iomem_wdata;
            sel_d   = (|iomem_wstrb) ? iomem_wstrb : 4'hF;
`ifdef IOMEM_WB_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            // Unmapped: answer immediately with an error, no Wishbone cycle.
            state_d = DONE;
            ready_d = 1'b1;
            rdata_d = ERR_DATA;
            err_inc = 1'b1;
          end
        end
      end

      WAIT: begin
        if (ack_sel) begin
          state_d = DONE;
          ready_d = 1'b1;
          rdata_d = dat_sel;
          cyc_d   = 1'b0;
          stb_d   = '0;
          we_d    = 1'b0;
        end
`ifdef IOMEM_WB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d = DONE;
          ready_d = 1'b1;
          rdata_d = ERR_DATA;
          err_inc = 1'b1;
          cyc_d   = 1'b0;
          stb_d   = '0;
          we_d    = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end

      // One idle cycle lets picosoc drop valid before the next sample.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    err_d = (err_inc && (err_count != '1)) ? err_count + ERR_CNT_W'(1) : err_count;
  end

  // NOTE: reset is synchronous active-low; it clears the bus cycle on the very next edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= '0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      iomem_rdata <= '0;
      iomem_ready <= 1'b0;
      err_count   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state_q     <= state_d;
      idx_q       <= idx_d;
      wbm_cyc_o   <= cyc_d;
      wbm_stb_o   <= stb_d;
      wbm_we_o    <= we_d;
      wbm_adr_o   <= adr_d;
      wbm_dat_o   <= dat_d;
      wbm_sel_o   <= sel_d;
      iomem_rdata <= rdata_d;
      iomem_ready <= ready_d;
      err_count   <= err_d;
    end
  end

`ifdef IOMEM_WB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!resetn) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`endif

endmodule

// File: tb/tb_iomem_wb_bridge.sv
// Scoreboard bench for iomem_wb_bridge: a driver issues directed accesses and
// queues expected responses; monitors compare at every ready pulse and bus cycle.
module tb_iomem_wb_bridge;

  localparam int NS  = 4;
  localparam int TMO = 16;

  logic               clk = 1'b0;
  logic               resetn;
  logic               iomem_valid;
  logic               iomem_ready;
  logic [3:0]         iomem_wstrb;
  logic [31:0]        iomem_addr;
  logic [31:0]        iomem_wdata;
  logic [31:0]        iomem_rdata;
  logic [31:0]        wbm_adr_o;
  logic [31:0]        wbm_dat_o;
  logic               wbm_we_o;
  logic [3:0]         wbm_sel_o;
  logic               wbm_cyc_o;
  logic [NS-1:0]      wbm_stb_o;
  logic [NS-1:0]      wbm_ack_i;
  logic [32*NS-1:0]   wbm_dat_i;
  logic [7:0]         err_count;

  always #5 clk = ~clk;

  iomem_wb_bridge #(
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i),
    .err_count   (err_count)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave models: slave 0 is an LED register, 1..3 are fixed-data stubs.
  int          dly[NS]      = '{1, 3, 1, 2};
  bit          never[NS]    = '{0, 0, 1, 0};
  int          cnt[NS]      = '{default: 0};
  logic [31:0] slv_data[NS] = '{32'h0, 32'h1234_5678, 32'h5555_AAAA, 32'h0C0F_FEE3};
  bit          spur3        = 1'b0;
  logic [7:0]  leds         = 8'h00;
  logic [NS-1:0] ack_r      = '0;

  assign wbm_ack_i = ack_r;
  assign wbm_dat_i = {slv_data[3], slv_data[2], slv_data[1], {24'h0, leds}};

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (wbm_cyc_o === 1'b1 && wbm_stb_o[i] === 1'b1) cnt[i] = cnt[i] + 1;
      else                                            cnt[i] = 0;
      ack_r[i] = !never[i] && (cnt[i] == dly[i]);
    end
    if (spur3 && cnt[1] == 2) ack_r[3] = 1'b1;
    if (ack_r[0] && wbm_we_o && wbm_sel_o[0]) leds = wbm_dat_o[7:0];
  end

  longint cyc_n = 0;
  always @(posedge clk) cyc_n++;

  typedef struct {
    logic [31:0] rdata;
    logic [7:0]  err;
    longint      at;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic ready_prev = 1'b0;

  // Response monitor: every ready pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (iomem_ready === 1'b1) begin
      check("ready_single_cycle", 32'(ready_prev), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'(iomem_ready), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rdata", iomem_rdata, mon_e.rdata);
        check("err_count", 32'(err_count), 32'(mon_e.err));
        check("ready_cycle", 32'(cyc_n), 32'(mon_e.at));
      end
    end
    ready_prev = (iomem_ready === 1'b1);
  end

  // Bus monitor: shared master signals and the one-hot strobe during each cycle.
  logic [3:0]  exp_stb;
  logic        exp_we;
  logic [3:0]  exp_sel;
  logic [31:0] exp_adr, exp_dat;
  int          cyc_cycles = 0;

  always @(negedge clk) begin
    if (wbm_cyc_o === 1'b1) begin
      cyc_cycles++;
      check("wb_stb", 32'(wbm_stb_o), 32'(exp_stb));
      check("wb_we",  32'(wbm_we_o),  32'(exp_we));
      check("wb_sel", 32'(wbm_sel_o), 32'(exp_sel));
      check("wb_adr", wbm_adr_o, exp_adr);
      check("wb_dat", wbm_dat_o, exp_dat);
    end
  end

  logic [7:0] exp_err = 8'd0;

  // lat = cycles from valid being presented to the ready pulse.
  task automatic access(input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input int slv, input int lat,
                        input logic [31:0] exp_rdata, input bit is_err);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(negedge clk);
    if (is_err && exp_err != 8'd255) exp_err = exp_err + 8'd1;
    exp_stb    = (slv >= 0) ? 4'(1 << slv) : 4'h0;
    exp_we     = |wstrb;
    exp_sel    = (wstrb == 4'h0) ? 4'hF : wstrb;
    exp_adr    = addr;
    exp_dat    = wdata;
    cyc_cycles = 0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.at    = cyc_n + longint'(lat);
    sb.push_back(e);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (iomem_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    check("ready_seen", 32'(got), 32'd1);
    check("cyc_cycles", 32'(cyc_cycles), (slv >= 0) ? 32'(lat - 1) : 32'd0);
    if (!got) sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    exp_stb = 4'h0; exp_we = 1'b0; exp_sel = 4'h0; exp_adr = 32'h0; exp_dat = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(iomem_ready), 32'd0);
    check("rst_cyc",   32'(wbm_cyc_o),   32'd0);
    check("rst_stb",   32'(wbm_stb_o),   32'd0);
    check("rst_rdata", iomem_rdata,      32'd0);
    check("rst_err",   32'(err_count),   32'd0);
    check("rst_adr",   wbm_adr_o,        32'd0);
    resetn = 1'b1;

    // LED write, read-back, and a byte-1-only write that must leave the LEDs alone.
    access(32'h0300_0000, 4'hF, 32'h0000_00A5, 0, 2, 32'h0000_00A5, 1'b0);
    access(32'h0300_0010, 4'h0, 32'h0000_0000, 0, 2, 32'h0000_00A5, 1'b0);
    access(32'h0300_0000, 4'h2, 32'hFFFF_FFFF, 0, 2, 32'h0000_00A5, 1'b0);
    // Slave 1 read with a 3-cycle ack.
    access(32'h0400_0004, 4'h0, 32'h0000_0000, 1, 4, 32'h1234_5678, 1'b0);
    // Unmapped accesses, including just below slave 0's window.
    access(32'h0700_0000, 4'h0, 32'h0000_0000, -1, 1, 32'hDEAD_BEEF, 1'b1);
    access(32'h02FF_FFFF, 4'hF, 32'h1111_1111, -1, 1, 32'hDEAD_BEEF, 1'b1);
    // Top of slave 3's window.
    access(32'h06FF_FFFC, 4'h0, 32'h0000_0000, 3, 3, 32'h0C0F_FEE3, 1'b0);
    // Spurious ack from slave 3 while slave 1 is slow.
    dly[1] = 5;
    spur3  = 1'b1;
    access(32'h0400_0000, 4'h0, 32'h0000_0000, 1, 6, 32'h1234_5678, 1'b0);
    spur3  = 1'b0;
    dly[1] = 3;

`ifdef IOMEM_WB_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      access(32'h0500_0000, 4'h0, 32'h0000_0000, 2, TMO + 1, 32'hDEAD_BEEF, 1'b1);
`endif

    // Drive err_count into saturation.
    for (int i = 0; i < 300; i++)
      access(32'h0800_0000 + 32'(i), 4'h0, 32'h0, -1, 1, 32'hDEAD_BEEF, 1'b1);
    check("err_saturated", 32'(err_count), 32'd255);

    // Reset while waiting on a slave that never acks.
    @(negedge clk);
    exp_stb = 4'b0100; exp_we = 1'b0; exp_sel = 4'hF;
    exp_adr = 32'h0500_0000; exp_dat = 32'h0;
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0500_0000;
    iomem_wstrb = 4'h0;
    iomem_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("mid_wait_cyc", 32'(wbm_cyc_o), 32'd1);
    resetn      = 1'b0;
    iomem_valid = 1'b0;
    @(negedge clk);
    check("abort_cyc",   32'(wbm_cyc_o),   32'd0);
    check("abort_stb",   32'(wbm_stb_o),   32'd0);
    check("abort_ready", 32'(iomem_ready), 32'd0);
    check("abort_err",   32'(err_count),   32'd0);
    resetn  = 1'b1;
    exp_err = 8'd0;
    access(32'h0400_0008, 4'h0, 32'h0000_0000, 1, 4, 32'h1234_5678, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
